// File: rtl/uart_rx_param_if.sv
// Valid/ready frame delivery bundle for uart_rx_param.
// The master side (the receiver) drives the frame and its error flags, and the slave side returns m_ready.
interface uart_rx_param_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_perr;
    logic              m_ferr;

    modport master (output m_valid, m_data, m_perr, m_ferr, input m_ready);
    modport slave  (input m_valid, m_data, m_perr, m_ferr, output m_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start validation, parity/stop checking and a one-entry valid/ready holding register.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 1085,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_param_if.master m,
    output logic            overrun,
    output logic            brk
);
    localparam int CNT_W   = $clog2(CLK_DIV);
    localparam int HAS_PAR = (PARITY != 0) ? 1 : 0;
    localparam int NBITS   = DATA_W + HAS_PAR + STOP_BITS;
    localparam int IDX_W   = $clog2(NBITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] PAR_IDX  = IDX_W'(DATA_W);
    localparam logic [IDX_W-1:0] STOP_IDX = IDX_W'(DATA_W + HAS_PAR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
`ifdef UART_RX_BREAK_DET_EN
        BRKWAIT,
`endif
        SHIFT
    } state_t;

    logic              rx_m, rx_s, rx_prev;
    logic [1:0]        sync_fill;
    logic              armed;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              ferr_acc;
    logic              done;
    logic              done_perr;
    logic              done_ferr;
    logic              fall;
    logic              perr_now;
`ifdef UART_RX_BREAK_DET_EN
    logic              any_one;
`endif

    // armed only once a genuine high level has passed through the synchroniser,
    // so a line held low across reset release does not look like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_prev   <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) armed <= 1'b1;
        end
    end

    always_comb begin
        fall     = armed && rx_prev && !rx_s;
        perr_now = 1'b0;
        if (PARITY == 1)      perr_now = ~par_acc;
        else if (PARITY == 2) perr_now = par_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            ferr_acc  <= 1'b0;
            done      <= 1'b0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            any_one   <= 1'b0;
            brk       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            cnt      <= '0;
                            idx      <= '0;
                            par_acc  <= 1'b0;
                            ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                            any_one  <= 1'b0;
`endif
                            state    <= SHIFT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        any_one <= any_one | rx_s;
`endif
                        if (idx < PAR_IDX) shreg <= {rx_s, shreg[DATA_W-1:1]};
                        if (idx < STOP_IDX) par_acc <= par_acc ^ rx_s;
                        else if (!rx_s)     ferr_acc <= 1'b1;
                        // parity is complete before the first stop bit, so perr_now is final here
                        if (idx == LAST_IDX) begin
                            done_perr <= perr_now;
                            done_ferr <= ferr_acc | ~rx_s;
`ifdef UART_RX_BREAK_DET_EN
                            if (!(any_one | rx_s)) begin
                                brk   <= 1'b1;
                                state <= BRKWAIT;
                            end else begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
`else
                            done  <= 1'b1;
                            state <= IDLE;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                BRKWAIT: begin
                    if (rx_s) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_BREAK_DET_EN
    assign brk = 1'b0;
`endif

    // completed frame lands one cycle after its last stop sample; shreg is idle by then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_perr  <= 1'b0;
            m.m_ferr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!m.m_valid || m.m_ready) begin
                    m.m_valid <= 1'b1;
                    m.m_data  <= shreg;
                    m.m_perr  <= done_perr;
                    m.m_ferr  <= done_ferr;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m.m_ready) begin
                m.m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: 8N1 and 8E2 instances, directed plus randomized frames.
// Expected frames come from a bit-level frame builder and a parity/stop reference computed arithmetically.
module tb_uart_rx_param;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic ovr0, ovr1, brk0, brk1;

    uart_rx_param_if #(.DATA_W(8)) if0 ();
    uart_rx_param_if #(.DATA_W(8)) if1 ();

    uart_rx_param #(.DATA_W(8), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .m(if0), .overrun(ovr0), .brk(brk0));
    uart_rx_param #(.DATA_W(8), .CLK_DIV(DIV), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .m(if1), .overrun(ovr1), .brk(brk1));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frm_t;

    frm_t got0[$], got1[$], expq[$];
    int unsigned ovr_cnt0 = 0, ovr_cnt1 = 0, brk_cnt0 = 0, vhi0 = 0, rise0 = 0;
    logic vprev0 = 1'b0;

    // consumer-side monitor: records accepted frames and pulse/valid activity
    always @(negedge clk) begin
        if (if0.m_valid && if0.m_ready) got0.push_back({if0.m_data, if0.m_perr, if0.m_ferr});
        if (if1.m_valid && if1.m_ready) got1.push_back({if1.m_data, if1.m_perr, if1.m_ferr});
        if (if0.m_valid) vhi0++;
        if (if0.m_valid && !vprev0) rise0 = cyc;
        vprev0 = if0.m_valid;
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
        if (brk0) brk_cnt0++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int w, input logic b);
        if (w == 0) rx0 = b;
        else        rx1 = b;
    endtask

    task automatic send_bits(input int w, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(w, bits[i]);
            tick(DIV);
        end
        set_rx(w, 1'b1);
    endtask

    function automatic logic [15:0] frame0(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame1(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        return {4'b0, s2, s1, p, d, 1'b0};
    endfunction

    function automatic int fsize(input int w);
        return (w == 0) ? got0.size() : got1.size();
    endfunction

    task automatic wait_frames(input string tag, input int w, input int n);
        for (int t = 0; t < 60 * DIV && fsize(w) < n; t++) tick();
        chk(tag, fsize(w), n);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid0"}, if0.m_valid, 0);
        chk({tag, "_data0"},  if0.m_data, 0);
        chk({tag, "_perr0"},  if0.m_perr, 0);
        chk({tag, "_ferr0"},  if0.m_ferr, 0);
        chk({tag, "_ovr0"},   ovr0, 0);
        chk({tag, "_brk0"},   brk0, 0);
        chk({tag, "_valid1"}, if1.m_valid, 0);
        chk({tag, "_data1"},  if1.m_data, 0);
    endtask

    initial begin
        logic [7:0]  d;
        logic        s, s1, s2, p, pe;
        int unsigned t0, v, o, b;
        frm_t        f;

        if0.m_ready = 1'b0;
        if1.m_ready = 1'b0;
        rst = 1'b0;
        tick(5);
        chk_outputs_zero("reset");
        rst = 1'b1;
        tick(5);

        // basic 8N1 frame with latency and single-cycle valid
        if0.m_ready = 1'b1;
        v  = vhi0;
        t0 = cyc;
        send_bits(0, frame0(8'hA5, 1'b1), 10);
        wait_frames("basic_count", 0, 1);
        tick(2);
        if (got0.size() > 0) chk("basic_frame", got0.pop_front(), {8'hA5, 1'b0, 1'b0});
        chk("basic_latency", rise0 - t0, 156);
        chk("basic_valid_width", vhi0 - v, 1);

        // randomized 8N1 stream, occasional bad stop bit
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            if (!s && d == 8'h00) d = 8'h01;
            expq.push_back({d, 1'b0, ~s});
            send_bits(0, frame0(d, s), 10);
            if (!s) tick(DIV);
        end
        wait_frames("rand0_count", 0, 8);
        while (expq.size() > 0 && got0.size() > 0) chk("rand0_frame", got0.pop_front(), expq.pop_front());
        expq.delete();

        // short low glitch must not start a frame
        rx0 = 1'b0;
        tick(4);
        rx0 = 1'b1;
        tick(12 * DIV);
        chk("glitch_frames", got0.size(), 0);
        chk("glitch_valid", if0.m_valid, 0);

        // framing error
        send_bits(0, frame0(8'h3C, 1'b0), 10);
        tick(DIV);
        wait_frames("ferr_count", 0, 1);
        if (got0.size() > 0) chk("ferr_frame", got0.pop_front(), {8'h3C, 1'b0, 1'b1});

        // stall and overrun
        if0.m_ready = 1'b0;
        o = ovr_cnt0;
        send_bits(0, frame0(8'h11, 1'b1), 10);
        send_bits(0, frame0(8'h22, 1'b1), 10);
        tick(4);
        chk("stall_valid", if0.m_valid, 1);
        chk("stall_data", if0.m_data, 8'h11);
        chk("overrun_once", ovr_cnt0 - o, 1);
        if0.m_ready = 1'b1;
        tick(1);
        if0.m_ready = 1'b0;
        tick(1);
        chk("stall_drain_count", got0.size(), 1);
        if (got0.size() > 0) chk("stall_frame", got0.pop_front(), {8'h11, 1'b0, 1'b0});
        chk("stall_valid_after", if0.m_valid, 0);
        if0.m_ready = 1'b1;

        // all-zero line for 12 bit times
        b = brk_cnt0;
        o = ovr_cnt0;
        rx0 = 1'b0;
        tick(12 * DIV);
        rx0 = 1'b1;
        tick(2 * DIV);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulse", brk_cnt0 - b, 1);
        chk("break_frames", got0.size(), 0);
        chk("break_valid", if0.m_valid, 0);
        chk("break_overrun", ovr_cnt0 - o, 0);
`else
        chk("zero_brk_none", brk_cnt0 - b, 0);
        chk("zero_count", got0.size(), 1);
        if (got0.size() > 0) chk("zero_frame", got0.pop_front(), {8'h00, 1'b0, 1'b1});
`endif
        send_bits(0, frame0(8'h55, 1'b1), 10);
        wait_frames("after_break_count", 0, 1);
        if (got0.size() > 0) chk("after_break_frame", got0.pop_front(), {8'h55, 1'b0, 1'b0});

        // reset released with line low: no start until a real falling edge
        b = brk_cnt0;
        rst = 1'b0;
        rx0 = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(12 * DIV);
        chk("rstlow_frames", got0.size(), 0);
        chk("rstlow_brk", brk_cnt0 - b, 0);
        rx0 = 1'b1;
        tick(2 * DIV);

        // reset mid-frame with a frame held
        if0.m_ready = 1'b0;
        send_bits(0, frame0(8'h5A, 1'b1), 10);
        tick(4);
        chk("held_valid", if0.m_valid, 1);
        chk("held_data", if0.m_data, 8'h5A);
        send_bits(0, frame0(8'hF0, 1'b1), 5);
        tick(DIV / 2);
        rst = 1'b0;
        tick(2);
        chk_outputs_zero("midreset");
        rst = 1'b1;
        if0.m_ready = 1'b1;
        tick(4);
        send_bits(0, frame0(8'h81, 1'b1), 10);
        wait_frames("midreset_count", 0, 1);
        if (got0.size() > 0) chk("midreset_frame", got0.pop_front(), {8'h81, 1'b0, 1'b0});

        // 8E2 instance: directed parity cases
        if1.m_ready = 1'b1;
        send_bits(1, frame1(8'h07, 1'b1, 1'b1, 1'b1), 12);
        send_bits(1, frame1(8'h07, 1'b0, 1'b1, 1'b1), 12);
        wait_frames("even_count", 1, 2);
        if (got1.size() > 0) chk("even_ok", got1.pop_front(), {8'h07, 1'b0, 1'b0});
        if (got1.size() > 0) chk("even_bad", got1.pop_front(), {8'h07, 1'b1, 1'b0});

        // 8E2 randomized: parity and either stop bit may be corrupted
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pe = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            if (!s2 && d == 8'h00) d = 8'h80;
            p = (($countones(d) % 2) != 0) ? ~pe : pe;
            expq.push_back({d, (($countones({d, p}) % 2) != 0), !(s1 && s2)});
            send_bits(1, frame1(d, p, s1, s2), 12);
            if (!s2) tick(DIV);
        end
        wait_frames("rand1_count", 1, 8);
        while (expq.size() > 0 && got1.size() > 0) chk("rand1_frame", got1.pop_front(), expq.pop_front());
        chk("rand1_no_overrun", ovr_cnt1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
